// File: rtl/cmp_check_pkg.sv
// Shared definitions for the comparator sweep checker.
//   state_t        : sweep FSM states
//   LT/GT/EQ_BIT   : bit positions of the flags inside a {lt,gt,eq} vector
//   FLAG_*         : one-hot encodings of the three legal comparator answers
package cmp_check_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int LT_BIT = 2;
   localparam int GT_BIT = 1;
   localparam int EQ_BIT = 0;

   localparam logic [2:0] FLAG_LT = 3'b100;
   localparam logic [2:0] FLAG_GT = 3'b010;
   localparam logic [2:0] FLAG_EQ = 3'b001;

endpackage

// File: rtl/cmp_golden_model.sv
// Reference magnitude comparator (purely combinational).
//   a, b  : unsigned WIDTH-bit operands
//   flags : expected {lt,gt,eq}, always exactly one bit set
module cmp_golden_model
   import cmp_check_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [2:0]       flags
);

   always_comb begin
      flags = FLAG_EQ;
      if (a < b) begin
         flags = FLAG_LT;
      end else if (a > b) begin
         flags = FLAG_GT;
      end
   end

endmodule

// File: rtl/comparator_sweep_checker.sv
// Exhaustive self-test engine for an N-bit magnitude comparator.
// Drives every {A,B} pair (B is the inner loop), waits SETTLE cycles per
// vector, then checks {lt,gt,eq} against the golden model.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : begin a sweep (honoured only when idle or done)
//   a_out, b_out       : operands driven to the comparator under test
//   lt_in, gt_in, eq_in: comparator response
//   busy, done, pass   : sweep status (pass meaningful when done=1)
//   err_count          : number of failing vectors
//   fail_valid, fail_a, fail_b, fail_flags : first captured failure
module comparator_sweep_checker
   import cmp_check_pkg::*;
#(
   parameter int WIDTH  = 2,
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [WIDTH-1:0]   a_out,
   output logic [WIDTH-1:0]   b_out,
   input  logic               lt_in,
   input  logic               gt_in,
   input  logic               eq_in,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic               fail_valid,
   output logic [WIDTH-1:0]   fail_a,
   output logic [WIDTH-1:0]   fail_b,
   output logic [2:0]         fail_flags
);

   localparam int VW = 2 * WIDTH;

   state_t           state_q;
   logic [3:0]       cnt_q;
   logic [VW-1:0]    vec_q;        // {A,B}; B in the LSBs so it sweeps fastest
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [VW:0]      err_q;
   logic [VW:0]      err_d;
   logic             fail_valid_q;
   logic [WIDTH-1:0] fail_a_q;
   logic [WIDTH-1:0] fail_b_q;
   logic [2:0]       fail_flags_q;

   logic [2:0]       obs_flags;
   logic [2:0]       exp_flags;
   logic             mismatch;

   cmp_golden_model #(.WIDTH(WIDTH)) u_golden (
      .a     (vec_q[VW-1:WIDTH]),
      .b     (vec_q[WIDTH-1:0]),
      .flags (exp_flags)
   );

   always_comb begin
      obs_flags         = '0;
      obs_flags[LT_BIT] = lt_in;
      obs_flags[GT_BIT] = gt_in;
      obs_flags[EQ_BIT] = eq_in;
   end

   // A whole-vector compare also catches non-one-hot answers (000, 111, ...).
   assign mismatch = (obs_flags != exp_flags);
   assign err_d    = err_q + {{VW{1'b0}}, mismatch};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         vec_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_q        <= '0;
         fail_valid_q <= 1'b0;
         fail_a_q     <= '0;
         fail_b_q     <= '0;
         fail_flags_q <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  vec_q        <= '0;
                  err_q        <= '0;
                  fail_valid_q <= 1'b0;
                  fail_a_q     <= '0;
                  fail_b_q     <= '0;
                  fail_flags_q <= '0;
                  done_q       <= 1'b0;
                  pass_q       <= 1'b0;
                  busy_q       <= 1'b1;
                  cnt_q        <= 4'(SETTLE);
                  state_q      <= (SETTLE == 0) ? CHECK : WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               err_q <= err_d;
               if (mismatch && !fail_valid_q) begin
                  fail_valid_q <= 1'b1;
                  fail_a_q     <= vec_q[VW-1:WIDTH];
                  fail_b_q     <= vec_q[WIDTH-1:0];
                  fail_flags_q <= obs_flags;
               end
               if (&vec_q) begin
                  // Last vector: operands stay at all ones.
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_d == '0);
                  state_q <= DONE;
               end else begin
                  vec_q   <= vec_q + 1'b1;
                  cnt_q   <= 4'(SETTLE);
                  state_q <= (SETTLE == 0) ? CHECK : WAIT;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign a_out      = vec_q[VW-1:WIDTH];
   assign b_out      = vec_q[WIDTH-1:0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_valid = fail_valid_q;
   assign fail_a     = fail_a_q;
   assign fail_b     = fail_b_q;
   assign fail_flags = fail_flags_q;

endmodule

// File: tb/tb_comparator_sweep_checker.sv
module tb_comparator_sweep_checker;

   typedef struct packed {
      logic [1:0] a;
      logic [1:0] b;
      logic       busy;
      logic       done;
      logic       pass;
      logic [4:0] err;
      logic       fv;
      logic [1:0] fa;
      logic [1:0] fb;
      logic [2:0] ff;
   } obs_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // dut1: SETTLE=1 with a fault-injectable comparator; dut0: SETTLE=0, ideal comparator
   logic       start1 = 1'b0, start0 = 1'b0;
   logic [1:0] a1, b1, a0, b0;
   logic       lt1, gt1, eq1, lt0, gt0, eq0;
   logic       busy1, done1, pass1, busy0, done0, pass0;
   logic [4:0] err1, err0;
   logic       fv1, fv0;
   logic [1:0] fa1, fb1, fa0, fb0;
   logic [2:0] ff1, ff0;
   int         mode = 0;   // 0 ideal, 1 eq stuck 0, 2 lt/gt swapped, 3 all ones

   int n_checks = 0;
   int n_fail   = 0;
   int n_print  = 0;

   comparator_sweep_checker #(.WIDTH(2), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1),
      .lt_in(lt1), .gt_in(gt1), .eq_in(eq1), .busy(busy1), .done(done1),
      .pass(pass1), .err_count(err1), .fail_valid(fv1), .fail_a(fa1),
      .fail_b(fb1), .fail_flags(ff1));

   comparator_sweep_checker #(.WIDTH(2), .SETTLE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .a_out(a0), .b_out(b0),
      .lt_in(lt0), .gt_in(gt0), .eq_in(eq0), .busy(busy0), .done(done0),
      .pass(pass0), .err_count(err0), .fail_valid(fv0), .fail_a(fa0),
      .fail_b(fb0), .fail_flags(ff0));

   function automatic logic [2:0] ideal(int a, int b);
      if (a < b) return 3'b100;
      if (a > b) return 3'b010;
      return 3'b001;
   endfunction

   function automatic logic [2:0] resp(int a, int b, int m);
      logic [2:0] r;
      r = ideal(a, b);
      case (m)
         1: r = r & 3'b110;
         2: r = {r[1], r[2], r[0]};
         3: r = 3'b111;
         default: ;
      endcase
      return r;
   endfunction

   assign {lt1, gt1, eq1} = resp(int'(a1), int'(b1), mode);
   assign {lt0, gt0, eq0} = resp(int'(a0), int'(b0), 0);

   // Expected outputs e edges after the start edge, from the timing rule
   // "each vector costs s+1 cycles" and a scan of the vectors already checked.
   function automatic obs_t predict(bit run, int e, int s, int m);
      obs_t o;
      int   total, checked, k, errs;
      logic [2:0] r;
      o = '0;
      if (!run) return o;
      total   = 16 * (s + 1);
      checked = e / (s + 1);
      if (checked > 16) checked = 16;
      k = (checked > 15) ? 15 : checked;
      o.a  = 2'(k / 4);
      o.b  = 2'(k % 4);
      errs = 0;
      for (int i = 0; i < checked; i++) begin
         r = resp(i / 4, i % 4, m);
         if (r != ideal(i / 4, i % 4)) begin
            if (errs == 0) begin
               o.fv = 1'b1;
               o.fa = 2'(i / 4);
               o.fb = 2'(i % 4);
               o.ff = r;
            end
            errs++;
         end
      end
      o.err  = 5'(errs);
      o.done = (e >= total);
      o.busy = !o.done;
      o.pass = o.done && (errs == 0);
      return o;
   endfunction

   // Model state: whether a run is active, cycle of its start edge, fault mode latched at start
   bit run1 = 0, run0 = 0;
   int cyc1 = 0, cyc0 = 0, st1 = 0, st0 = 0, m1 = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run1 = 0;
      end else begin
         if (start1 && !(run1 && (cyc1 - st1) < 32)) begin
            run1 = 1;
            st1  = cyc1 + 1;
            m1   = mode;
         end
         cyc1 = cyc1 + 1;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run0 = 0;
      end else begin
         if (start0 && !(run0 && (cyc0 - st0) < 16)) begin
            run0 = 1;
            st0  = cyc0 + 1;
         end
         cyc0 = cyc0 + 1;
      end
   end

   task automatic chk(string nm, longint act, longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         if (n_print < 40) begin
            n_print++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
         end
      end
   endtask

   bit   cmp_en = 1'b1;
   obs_t act1, act0;
   assign act1 = {a1, b1, busy1, done1, pass1, err1, fv1, fa1, fb1, ff1};
   assign act0 = {a0, b0, busy0, done0, pass0, err0, fv0, fa0, fb0, ff0};

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("dut1_cycle", act1, predict(run1, cyc1 - st1, 1, m1));
         chk("dut0_cycle", act0, predict(run0, cyc0 - st0, 0, 0));
      end
   end

   // Start (held for 'hold' cycles) and return cycles from start edge to done rising.
   task automatic sweep(input bit which, input int hold, output int lat);
      bit d;
      if (which) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      lat = 0;
      for (int i = 1; i < hold; i++) begin
         @(negedge clk);
         lat++;
      end
      start1 = 1'b0;
      start0 = 1'b0;
      d = which ? done1 : done0;
      while (!d && lat < 200) begin
         @(negedge clk);
         lat++;
         d = which ? done1 : done0;
      end
   endtask

   int lat;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_state", act1, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Ideal comparator, one pulse
      sweep(1, 1, lat);
      $display("sweep ideal: latency=%0d err=%0d pass=%0b", lat, err1, pass1);
      chk("ideal_latency", lat, 32);
      chk("ideal_pass", pass1, 1);
      chk("ideal_err", err1, 0);
      chk("ideal_fv", fv1, 0);
      chk("ideal_ab_hold", {a1, b1}, 4'hf);

      // eq stuck at 0; also restart from DONE
      mode = 1;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("restart_done_clr", done1, 0);
      chk("restart_busy", busy1, 1);
      lat = 0;
      while (!done1 && lat < 200) begin @(negedge clk); lat++; end
      $display("sweep eq0: err=%0d pass=%0b fail=%0h/%0h/%03b", err1, pass1, fa1, fb1, ff1);
      chk("eq0_err", err1, 4);
      chk("eq0_pass", pass1, 0);
      chk("eq0_fail_ab", {fa1, fb1}, 4'h0);
      chk("eq0_flags", ff1, 3'b000);

      // lt/gt swapped, start held 10 cycles while busy
      mode = 2;
      sweep(1, 10, lat);
      $display("sweep swap: latency=%0d err=%0d fail=%0h/%0h/%03b", lat, err1, fa1, fb1, ff1);
      chk("held_start_latency", lat, 32);
      chk("swap_err", err1, 12);
      chk("swap_fail_ab", {fa1, fb1}, 4'h1);
      chk("swap_flags", ff1, 3'b010);

      // all flags high
      mode = 3;
      sweep(1, 1, lat);
      $display("sweep ones: err=%0d fail=%0h/%0h/%03b", err1, fa1, fb1, ff1);
      chk("ones_err", err1, 16);
      chk("ones_fv", fv1, 1);
      chk("ones_flags", ff1, 3'b111);
      chk("ones_fail_ab", {fa1, fb1}, 4'h0);

      // Reset during the 7th vector (A=01,B=10)
      mode = 0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      lat = 0;
      while (!(a1 == 2'd1 && b1 == 2'd2) && lat < 100) begin @(negedge clk); lat++; end
      chk("reach_vec7", {a1, b1}, 4'h6);
      #2 rst_n = 1'b0;
      #1;
      $display("async reset mid-sweep: outputs=0x%0h", act1);
      chk("async_reset_zero", act1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sweep(1, 1, lat);
      $display("sweep after reset: latency=%0d pass=%0b err=%0d", lat, pass1, err1);
      chk("post_reset_pass", pass1, 1);
      chk("post_reset_err", err1, 0);

      // SETTLE=0 instance
      sweep(0, 1, lat);
      $display("sweep settle0: latency=%0d pass=%0b", lat, pass0);
      chk("settle0_latency", lat, 16);
      chk("settle0_pass", pass0, 1);

      repeat (2) @(negedge clk);
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
